// File: rtl/rs_latch_driver_pkg.sv
// Shared definitions for the set/reset latch driver: FSM state codes and
// the helper used to size the shared down-counter.
package rs_latch_driver_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_PULSE = 2'd1;
    localparam state_t S_CHECK = 2'd2;
    localparam state_t S_GAP   = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/rs_latch_driver_if.sv
// Command handshake plus latch drive/readback bundle between control logic
// (master) and the latch driver (slave).
interface rs_latch_driver_if;

    logic req_valid;
    logic req_value;
    logic req_ready;
    logic latch_set;
    logic latch_rst;
    logic q_fb;
    logic busy;
    logic done;
    logic error;

    modport master (
        output req_valid, req_value, q_fb,
        input  req_ready, latch_set, latch_rst, busy, done, error
    );

    modport slave (
        input  req_valid, req_value, q_fb,
        output req_ready, latch_set, latch_rst, busy, done, error
    );

endinterface

// File: rtl/rs_down_counter.sv
// Loadable down-counter that stops at zero; one instance is time-shared by
// the pulse, timeout and gap phases of the driver.
module rs_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/rs_latch_driver.sv
// Turns one-bit write commands into a single bounded set or reset pulse,
// then waits for the latch readback and reports done/error.
module rs_latch_driver
    import rs_latch_driver_pkg::*;
#(
    parameter int PULSE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int GAP_CYCLES     = 1
) (
    input  logic               clk,
    input  logic               reset,
    rs_latch_driver_if.slave   bus
);

    localparam int CW = $clog2(max3(PULSE_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD     = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t        state_q, state_d;
    logic          val_q, val_d;
    logic          set_q, set_d;
    logic          rst_q, rst_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          cnt_load_s;
    logic [CW-1:0] cnt_val_s;
    logic          cnt_en_s;
    logic          cnt_zero_s;

    rs_down_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .en       (cnt_en_s),
        .zero     (cnt_zero_s)
    );

    // FSM next state, counter control and completion status.
    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        cnt_load_s = 1'b0;
        cnt_val_s  = {CW{1'b0}};
        cnt_en_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d    = S_PULSE;
                    val_d      = bus.req_value;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = PULSE_LD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PULSE: begin
                if (cnt_zero_s) begin
                    state_d    = S_CHECK;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = TIMEOUT_LD;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            S_CHECK: begin
                if ((bus.q_fb == val_q) || cnt_zero_s) begin
                    done_d  = 1'b1;
                    error_d = (bus.q_fb != val_q);
                    if (GAP_CYCLES > 0) begin
                        state_d    = S_GAP;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = GAP_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_zero_s) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Drives are decoded from the next state so set and reset are mutually exclusive by construction.
    always_comb begin
        set_d   = (state_d == S_PULSE) &  val_d;
        rst_d   = (state_d == S_PULSE) & ~val_d;
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset drops the drives immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            val_q   <= 1'b0;
            set_q   <= 1'b0;
            rst_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            set_q   <= set_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.latch_set = set_q;
    assign bus.latch_rst = rst_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.busy      = busy_q;
    assign bus.req_ready = ready_q;

endmodule
